// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID pipeline register.
// Owns PCF, issues one outstanding instruction-memory request at a time,
// buffers a response while decode is stalled, applies EX redirects and
// hazard-unit stall/flush, and presents InstrD/PCD/PCPlus4D/ValidD to decode.
// Optional feature macro: FETCH_PERF_CNT_EN (adds FetchCountF/StallCountF).
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReqValidF,
    input  logic            ImemReqReadyF,
    output logic [XLEN-1:0] ImemAddrF,
    input  logic            ImemRspValidF,
    input  logic [31:0]     ImemRspDataF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     FetchCountF,
    output logic [31:0]     StallCountF
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pcf_next;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] load_pc;
    logic [31:0]     buf_instr;
    logic [31:0]     load_instr;
    logic            drop_pending;
    logic            drop_next;
    logic            req_fire;
    logic            redirect;
    logic            rsp_take;
    logic            rsp_buf;
    logic            buf_take;
    logic            load;
    logic            unused_tgt_lsb;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    assign target         = {PCTargetE[XLEN-1:2], 2'b00};
    assign unused_tgt_lsb = ^PCTargetE[1:0];
    assign req_fire       = (state == S_REQ) && ImemReqReadyF;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect with a response in WAIT discards it.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ:  if (req_fire) state_next = S_WAIT;
            S_WAIT: begin
                if (ImemRspValidF) begin
                    state_next = (drop_pending || PCSrcE || !StallD) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: if (PCSrcE || !StallD) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    // Output and datapath control decode.
    always_comb begin
        ImemReqValidF = (state == S_REQ);
        ImemAddrF     = pcf;
        redirect      = PCSrcE && (state != S_IDLE);
        rsp_take      = 1'b0;
        rsp_buf       = 1'b0;
        buf_take      = 1'b0;
        if ((state == S_WAIT) && ImemRspValidF && !drop_pending && !PCSrcE) begin
            rsp_take = !StallD;
            rsp_buf  = StallD;
        end
        if ((state == S_HOLD) && !PCSrcE && !StallD) begin
            buf_take = 1'b1;
        end
        load       = rsp_take || buf_take;
        load_instr = rsp_take ? ImemRspDataF : buf_instr;
        load_pc    = rsp_take ? pcf : buf_pc;

        pcf_next = pcf;
        if (redirect) begin
            pcf_next = target;
        end else if (load) begin
            pcf_next = pcf + XLEN'(4);
        end

        // A request in flight across a redirect must have its response dropped.
        drop_next = drop_pending;
        if ((state == S_WAIT) && ImemRspValidF) begin
            drop_next = 1'b0;
        end else if (redirect && ((state == S_WAIT) || req_fire)) begin
            drop_next = 1'b1;
        end
    end

    // Fetch PC and stale-response marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf          <= RESET_PC;
            drop_pending <= 1'b0;
        end else begin
            pcf          <= pcf_next;
            drop_pending <= drop_next;
        end
    end

    // Response buffer used while decode is stalled; occupancy is implied by HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (rsp_buf) begin
            buf_instr <= ImemRspDataF;
            buf_pc    <= pcf;
        end
    end

    // IF/ID register: flush beats load and stall; an unstalled empty cycle is a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (load) begin
            InstrD   <= load_instr;
            PCD      <= load_pc;
            PCPlus4D <= load_pc + XLEN'(4);
            ValidD   <= 1'b1;
        end else if (!StallD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: valid decode loads and memory/decode stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCountF <= '0;
            StallCountF <= '0;
        end else begin
            if (load && !FlushD) begin
                FetchCountF <= FetchCountF + 32'd1;
            end
            if ((state == S_WAIT) || ((state == S_HOLD) && StallD)) begin
                StallCountF <= StallCountF + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic against a
// transaction-level fetch model (pc, in-flight flag, stale flag, held slot).
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallD, FlushD, PCSrcE, ImemReqReadyF, ImemRspValidF;
    logic [31:0] PCTargetE, ImemRspDataF;
    logic        ImemReqValidF, ValidD;
    logic [31:0] ImemAddrF, InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCountF, StallCountF;
`endif

    fetch_stage #(.XLEN(32), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemReqValidF(ImemReqValidF), .ImemReqReadyF(ImemReqReadyF), .ImemAddrF(ImemAddrF),
        .ImemRspValidF(ImemRspValidF), .ImemRspDataF(ImemRspDataF),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCountF(FetchCountF), .StallCountF(StallCountF)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Stimulus knobs
    logic        k_stall, k_flush, k_pcsrc, k_ready, junk_en;
    logic [31:0] k_tgt;
    int unsigned lat_lo, lat_hi;

    // Memory responder
    logic        r_pend;
    int unsigned r_cnt;
    logic [31:0] r_addr;

    // Behavioural model
    logic        m_started, m_out, m_stale, m_held, m_valid;
    logic [31:0] m_pc, m_hinstr, m_hpc, m_instr, m_pcd, m_pc4, m_fcnt, m_scnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    function automatic logic m_req();
        return m_started && !m_out && !m_held;
    endfunction

    task automatic model_reset();
        m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
        m_pc = RPC; m_hinstr = '0; m_hpc = '0;
        m_instr = NOP; m_pcd = '0; m_pc4 = '0; m_valid = 1'b0;
        m_fcnt = '0; m_scnt = '0;
        r_pend = 1'b0; r_cnt = 0; r_addr = '0;
    endtask

    // One clock of the fetch rules: held slot, in-flight request, or request phase.
    task automatic model_update(input logic st, input logic fl, input logic ps,
                                input logic [31:0] tg, input logic rdy,
                                input logic rv, input logic [31:0] rd);
        logic        ld;
        logic [31:0] li, lp, ta;
        ld = 1'b0; li = '0; lp = '0;
        ta = {tg[31:2], 2'b00};
        if (m_out || (m_held && st)) m_scnt = m_scnt + 32'd1;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_held) begin
            if (ps) begin
                m_pc = ta; m_held = 1'b0;
            end else if (!st) begin
                ld = 1'b1; li = m_hinstr; lp = m_hpc; m_pc = m_pc + 32'd4; m_held = 1'b0;
            end
        end else if (m_out) begin
            if (rv) begin
                m_out = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                    if (ps) m_pc = ta;
                end else if (ps) begin
                    m_pc = ta;
                end else if (!st) begin
                    ld = 1'b1; li = rd; lp = m_pc; m_pc = m_pc + 32'd4;
                end else begin
                    m_held = 1'b1; m_hinstr = rd; m_hpc = m_pc;
                end
            end else if (ps) begin
                m_pc = ta; m_stale = 1'b1;
            end
        end else begin
            if (rdy) m_out = 1'b1;
            if (ps) begin
                m_pc = ta;
                if (rdy) m_stale = 1'b1;
            end
        end
        if (fl) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (ld) begin
            m_instr = li; m_pcd = lp; m_pc4 = lp + 32'd4; m_valid = 1'b1;
            m_fcnt = m_fcnt + 32'd1;
        end else if (!st) begin
            m_instr = NOP; m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk1("req_valid", ImemReqValidF, m_req());
        chk("req_addr", ImemAddrF, m_pc);
        chk("instr_d", InstrD, m_instr);
        chk("pc_d", PCD, m_pcd);
        chk("pcplus4_d", PCPlus4D, m_pc4);
        chk1("valid_d", ValidD, m_valid);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", FetchCountF, m_fcnt);
        chk("stall_count", StallCountF, m_scnt);
`endif
    endtask

    // Drive one cycle from the knobs, advance model and responder, then compare.
    task automatic step();
        logic        rv, hs;
        logic [31:0] rd, a;
        StallD = k_stall; FlushD = k_flush; PCSrcE = k_pcsrc;
        PCTargetE = k_tgt; ImemReqReadyF = k_ready;
        rv = r_pend && (r_cnt == 0);
        rd = mem_word(r_addr);
        if (!r_pend && junk_en && ($urandom_range(0, 9) == 0)) begin
            rv = 1'b1; rd = $urandom;
        end
        ImemRspValidF = rv; ImemRspDataF = rd;
        hs = m_req() && k_ready;
        a  = m_pc;
        @(posedge clk);
        model_update(k_stall, k_flush, k_pcsrc, k_tgt, k_ready, rv, rd);
        if (r_pend && (r_cnt == 0)) r_pend = 1'b0;
        else if (r_pend) r_cnt = r_cnt - 1;
        if (hs) begin
            r_pend = 1'b1; r_addr = a; r_cnt = $urandom_range(lat_hi, lat_lo) - 1;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !ImemReqValidF; i++) step();
        if (!ImemReqValidF) begin
            n_total++;
            $display("FAIL wait_req: request valid got 0 expected 1 within 50 cycles");
        end
    endtask

    logic [31:0] dpc[3];
    logic [31:0] din[3];
    logic [31:0] dp4[3];
    int unsigned got;
    logic [31:0] si, sp, ep, a0;
    logic        sv;

    initial begin
        rst_n = 1'b0;
        StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        ImemReqReadyF = 0; ImemRspValidF = 0; ImemRspDataF = '0;
        k_stall = 0; k_flush = 0; k_pcsrc = 0; k_tgt = '0; k_ready = 1; junk_en = 0;
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 3; i++) begin dpc[i] = '0; din[i] = '0; dp4[i] = '0; end
        model_reset();
        #12;
        chk("rst_instr", InstrD, 32'h0000_0013);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk1("rst_valid", ValidD, 1'b0);
        chk1("rst_req", ImemReqValidF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Zero-wait memory: sequential fetch from RESET_PC
        step();
        chk1("first_req", ImemReqValidF, 1'b1);
        chk("first_addr", ImemAddrF, 32'h0000_0100);
        got = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            step();
            if (ValidD) begin
                dpc[got] = PCD; din[got] = InstrD; dp4[got] = PCPlus4D; got++;
            end
        end
        chk("seq0_pc", dpc[0], 32'h0000_0100);
        chk("seq0_instr", din[0], 32'h1357_9ADF);
        chk("seq1_pc", dpc[1], 32'h0000_0104);
        chk("seq1_instr", din[1], 32'h1357_9ADB);
        chk("seq2_pc", dpc[2], 32'h0000_0108);
        chk("seq2_instr", din[2], 32'h1357_9AD7);
        chk("seq2_pc4", dp4[2], 32'h0000_010C);

        // Response during a 3-cycle decode stall lands in the buffer
        wait_req();
        k_stall = 1;
        si = InstrD; sv = ValidD; sp = PCD; ep = ImemAddrF;
        chk("hold_req_pc", ep, 32'h0000_010C);
        step(); step();
        for (int i = 0; i < 3; i++) begin
            chk("hold_instr", InstrD, si);
            chk("hold_pcd", PCD, sp);
            chk1("hold_valid", ValidD, sv);
            chk1("hold_no_req", ImemReqValidF, 1'b0);
            step();
        end
        k_stall = 0;
        step();
        chk("unhold_instr", InstrD, mem_word(32'h0000_010C));
        chk("unhold_pcd", PCD, 32'h0000_010C);
        chk1("unhold_valid", ValidD, 1'b1);

        // Redirect while a request to 0x200 is in flight
        wait_req();
        k_ready = 0; k_pcsrc = 1; k_tgt = 32'h0000_0200;
        step();
        chk("redir_addr_200", ImemAddrF, 32'h0000_0200);
        k_pcsrc = 0; k_ready = 1; lat_lo = 3; lat_hi = 3;
        step();
        k_pcsrc = 1; k_tgt = 32'h0000_0403;
        step();
        k_pcsrc = 0; lat_lo = 1; lat_hi = 1;
        wait_req();
        chk("redir_addr_400", ImemAddrF, 32'h0000_0400);
        for (int i = 0; i < 30 && !ValidD; i++) step();
        chk("redir_first_pcd", PCD, 32'h0000_0400);
        chk("redir_first_instr", InstrD, 32'h1357_9FDF);

        // Flush and stall together
        k_flush = 1; k_stall = 1;
        step();
        chk("flush_instr", InstrD, 32'h0000_0013);
        chk1("flush_valid", ValidD, 1'b0);
        k_flush = 0; k_stall = 0;

        // Memory not ready for 5 cycles
        wait_req();
        k_ready = 0; a0 = ImemAddrF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("nrdy_req", ImemReqValidF, 1'b1);
            chk("nrdy_addr", ImemAddrF, a0);
        end

        // PC wrap at the top of the address space
        k_pcsrc = 1; k_tgt = 32'hFFFF_FFFE;
        step();
        chk("wrap_addr", ImemAddrF, 32'hFFFF_FFFC);
        k_pcsrc = 0; k_ready = 1;
        for (int i = 0; i < 30 && !(ValidD && PCD == 32'hFFFF_FFFC); i++) step();
        chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0000_0000);
        wait_req();
        chk("wrap_next_addr", ImemAddrF, 32'h0000_0000);

        // Randomized traffic
        junk_en = 1; lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            k_stall = ($urandom_range(0, 3) == 0);
            k_flush = ($urandom_range(0, 11) == 0);
            k_pcsrc = ($urandom_range(0, 11) == 0);
            k_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
            k_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
